// File: rtl/user_spi_pkg.sv
// Shared types for the user-domain SPI subordinate receiver.
package user_spi_pkg;

  localparam int BitsPerByte = 8;
  localparam int BitCntW     = $clog2(BitsPerByte);

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } spi_rx_entry_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_rx_state_e;

endpackage

// File: rtl/user_spi_sub_rx_fifo.sv
// Show-ahead FIFO holding received {dc,byte} entries; head is visible while not empty.
module user_spi_sub_rx_fifo
  import user_spi_pkg::*;
#(
  parameter int  Depth = 4,
  parameter type dtype = spi_rx_entry_t
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push,
  input  logic pop,
  input  dtype wr_data,
  output dtype rd_data,
  output logic full,
  output logic empty
);

  localparam int AddrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW  = AddrW + 1;

  logic [AddrW-1:0] wr_ptr;
  logic [AddrW-1:0] rd_ptr;
  logic [CntW-1:0]  count;
  dtype             mem [Depth];
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CntW'(Depth));
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/user_spi_sub_rx.sv
// SPI mode-0 subordinate receiver: oversamples SCK/MOSI/CS_n/DC, assembles MSB-first
// bytes tagged with D/C and buffers them for a valid/ready consumer.
module user_spi_sub_rx
  import user_spi_pkg::*;
#(
  parameter int FifoDepth  = 4,
  parameter int SyncStages = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       spi_sck_i,
  input  logic       spi_mosi_i,
  input  logic       spi_cs_n_i,
  input  logic       spi_dc_i,
  output logic [7:0] rx_data_o,
  output logic       rx_dc_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_active_o,
  output logic       frame_done_o,
  output logic       frame_abort_o,
  output logic       overflow_o,
  input  logic       clear_overflow_i
);

  // Pin order {dc, cs_n, mosi, sck}; idle bus is CS deasserted, everything else low.
  localparam logic [3:0] SyncReset = 4'b0100;

  logic [SyncStages-1:0][3:0] sync_q;
  logic [3:0]                 pins;
  logic [3:0]                 pins_s;
  logic [SyncStages:0]        warm_q;
  logic                       warm;
  logic                       sck_d;
  logic                       cs_d;
  logic                       sck_rise;
  logic                       cs_fall;
  logic                       cs_rise;
  logic                       mosi_q;
  logic                       dc_q;

  spi_rx_state_e              state_q, state_n;
  logic [BitCntW-1:0]         bit_cnt_q, bit_cnt_n;
  logic [BitsPerByte-2:0]     shift_q, shift_n;
  logic                       push_req;
  logic                       done;
  logic                       abort;
  spi_rx_entry_t              push_entry;
  spi_rx_entry_t              head;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       overflow_set;

  assign pins   = {spi_dc_i, spi_cs_n_i, spi_mosi_i, spi_sck_i};
  assign pins_s = sync_q[SyncStages-1];
  assign warm   = warm_q[SyncStages];

  // Edges are only trusted once the chain and the delay flop hold real pin samples,
  // so a frame already running at reset release is not joined mid-way.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= {SyncStages{SyncReset}};
      warm_q   <= '0;
      sck_d    <= SyncReset[0];
      cs_d     <= SyncReset[2];
      sck_rise <= 1'b0;
      cs_fall  <= 1'b0;
      cs_rise  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SyncStages-2:0], pins};
      warm_q   <= {warm_q[SyncStages-1:0], 1'b1};
      sck_d    <= pins_s[0];
      cs_d     <= pins_s[2];
      sck_rise <= warm &  pins_s[0] & ~sck_d;
      cs_fall  <= warm & ~pins_s[2] &  cs_d;
      cs_rise  <= warm &  pins_s[2] & ~cs_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mosi_q <= pins_s[1];
    dc_q   <= pins_s[3];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_n;
      bit_cnt_q <= bit_cnt_n;
      shift_q   <= shift_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    bit_cnt_n = bit_cnt_q;
    shift_n   = shift_q;
    push_req  = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_n   = ACTIVE;
          bit_cnt_n = '0;
          shift_n   = '0;
        end
      end
      ACTIVE: begin
        if (sck_rise) begin
          shift_n   = {shift_q[BitsPerByte-3:0], mosi_q};
          bit_cnt_n = bit_cnt_q + 1'b1;
          push_req  = (bit_cnt_q == BitCntW'(BitsPerByte - 1));
        end
        // A coincident SCK edge has already advanced bit_cnt_n above.
        if (cs_rise) begin
          if (bit_cnt_n == '0) done  = 1'b1;
          else                 abort = 1'b1;
          state_n   = IDLE;
          bit_cnt_n = '0;
          shift_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign push_entry = spi_rx_entry_t'{dc: dc_q, data: {shift_q, mosi_q}};

  user_spi_sub_rx_fifo #(
    .Depth (FifoDepth),
    .dtype (spi_rx_entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push    (push_req),
    .pop     (rx_ready_i),
    .wr_data (push_entry),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign overflow_set = push_req && fifo_full && !rx_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_o <= 1'b0;
    end else if (overflow_set) begin
      overflow_o <= 1'b1;
    end else if (clear_overflow_i) begin
      overflow_o <= 1'b0;
    end
  end

  assign rx_valid_o     = !fifo_empty;
  assign rx_data_o      = fifo_empty ? 8'h00 : head.data;
  assign rx_dc_o        = !fifo_empty && head.dc;
  assign frame_active_o = (state_q == ACTIVE);
  assign frame_done_o   = done;
  assign frame_abort_o  = abort;

endmodule

// File: tb/tb_user_spi_sub_rx.sv
// Scoreboard bench for user_spi_sub_rx: directed SPI frames, monitor pops and compares entries.
module tb_user_spi_sub_rx;

  localparam int FifoDepth  = 4;
  localparam int SyncStages = 2;
  localparam int Half       = 4;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck = 1'b0;
  logic       mosi = 1'b0;
  logic       cs_n = 1'b1;
  logic       dc = 1'b0;
  logic       ready = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_dc;
  logic       rx_valid;
  logic       frame_active;
  logic       frame_done;
  logic       frame_abort;
  logic       overflow;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   abort_cnt = 0;
  int   d0, a0;

  always #5 clk = ~clk;

  user_spi_sub_rx #(
    .FifoDepth  (FifoDepth),
    .SyncStages (SyncStages)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .spi_sck_i        (sck),
    .spi_mosi_i       (mosi),
    .spi_cs_n_i       (cs_n),
    .spi_dc_i         (dc),
    .rx_data_o        (rx_data),
    .rx_dc_o          (rx_dc),
    .rx_valid_o       (rx_valid),
    .rx_ready_i       (ready),
    .frame_active_o   (frame_active),
    .frame_done_o     (frame_done),
    .frame_abort_o    (frame_abort),
    .overflow_o       (overflow),
    .clear_overflow_i (clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done)  done_cnt++;
      if (frame_abort) abort_cnt++;
      if (rx_valid && ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected actual=%0h/%0b required=none", rx_data, rx_dc);
        end else begin
          mon_e = exp_q.pop_front();
          check("pop_data", 32'(rx_data), 32'(mon_e.data));
          check("pop_dc", 32'(rx_dc), 32'(mon_e.dc));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends the top n bits of d MSB first; the expected entry is queued before the last rise.
  task automatic send_bits(input logic [7:0] d, input int n, input logic dcv, input logic expect_push);
    for (int i = 0; i < n; i++) begin
      dc   = dcv;
      sck  = 1'b0;
      mosi = d[7-i];
      tick(Half);
      if (expect_push && i == n - 1) exp_q.push_back({dcv, d});
      sck = 1'b1;
      tick(Half);
    end
    sck = 1'b0;
    tick(Half);
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    tick(Half + 2);
  endtask

  task automatic cs_high();
    cs_n = 1'b1;
    tick(8);
  endtask

  task automatic drain(input string name);
    ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick(1);
    tick(2);
    check(name, 32'(exp_q.size()), 32'd0);
    ready = 1'b0;
  endtask

  initial begin
    tick(3);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_active", 32'(frame_active), 32'd0);
    check("rst_done_abort", 32'({frame_done, frame_abort}), 32'd0);
    rst_n = 1'b1;
    tick(5);

    // Single byte frame
    d0 = done_cnt; a0 = abort_cnt;
    cs_low();
    check("t1_active", 32'(frame_active), 32'd1);
    send_bits(8'hA5, 8, 1'b1, 1'b1);
    cs_high();
    check("t1_inactive", 32'(frame_active), 32'd0);
    check("t1_done", 32'(done_cnt - d0), 32'd1);
    check("t1_abort", 32'(abort_cnt - a0), 32'd0);
    check("t1_valid", 32'(rx_valid), 32'd1);
    check("t1_head", 32'({rx_dc, rx_data}), 32'h1A5);
    drain("t1_drained");

    // Streaming with consumer always ready
    ready = 1'b1;
    cs_low();
    send_bits(8'h01, 8, 1'b0, 1'b1);
    send_bits(8'h02, 8, 1'b1, 1'b1);
    send_bits(8'h03, 8, 1'b0, 1'b1);
    cs_high();
    drain("t2_drained");

    // Overflow: fifth byte dropped
    d0 = done_cnt;
    cs_low();
    for (int i = 0; i < FifoDepth + 1; i++)
      send_bits(8'(8'h10 + i), 8, 1'(i % 2), (i < FifoDepth) ? 1'b1 : 1'b0);
    cs_high();
    check("t3_done", 32'(done_cnt - d0), 32'd1);
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_valid", 32'(rx_valid), 32'd1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(1);
    check("t3_cleared", 32'(overflow), 32'd0);
    drain("t3_drained");
    check("t3_empty", 32'(rx_valid), 32'd0);

    // Partial byte aborts the frame
    d0 = done_cnt; a0 = abort_cnt;
    cs_low();
    send_bits(8'hFF, 8, 1'b0, 1'b1);
    send_bits(8'hA0, 5, 1'b1, 1'b0);
    cs_high();
    check("t4_abort", 32'(abort_cnt - a0), 32'd1);
    check("t4_done", 32'(done_cnt - d0), 32'd0);
    drain("t4_drained");
    check("t4_no_second", 32'(rx_valid), 32'd0);

    // Full FIFO with push and pop in the same cycle
    cs_low();
    for (int i = 0; i < FifoDepth; i++) send_bits(8'(8'h21 + i), 8, 1'b0, 1'b1);
    send_bits(8'h55, 7, 1'b1, 1'b0);
    dc   = 1'b1;
    mosi = 1'b1;
    tick(Half);
    exp_q.push_back({1'b1, 8'h55});
    sck = 1'b1;
    tick(SyncStages + 1);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    tick(Half);
    sck = 1'b0;
    tick(Half);
    cs_high();
    check("t5_overflow", 32'(overflow), 32'd0);
    check("t5_valid", 32'(rx_valid), 32'd1);
    drain("t5_drained");

    // Reset mid-byte, frame still selected at release
    d0 = done_cnt; a0 = abort_cnt;
    cs_low();
    send_bits(8'hC3, 4, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick(3);
    check("t6_rst_active", 32'(frame_active), 32'd0);
    rst_n = 1'b1;
    tick(2);
    send_bits(8'h99, 8, 1'b0, 1'b0);
    check("t6_not_joined", 32'(frame_active), 32'd0);
    cs_high();
    check("t6_no_push", 32'(rx_valid), 32'd0);
    check("t6_no_pulse", 32'((done_cnt - d0) + (abort_cnt - a0)), 32'd0);
    cs_low();
    send_bits(8'h3C, 8, 1'b0, 1'b1);
    cs_high();
    check("t6_done", 32'(done_cnt - d0), 32'd1);
    check("t6_head", 32'({rx_dc, rx_data}), 32'h03C);
    drain("t6_drained");

    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
